div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
//  Consumes rs/rt operands plus the signedness bit from decode, stalls the pipeline while iterating,
//  and produces {hi_out, lo_out} (remainder, quotient) for the HI/LO write path gated by HiLoWrite.
// PARAMETERS
//  WIDTH   32   operand/result width in bits; iteration count equals WIDTH
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      reset; synchronous, active-low (0 = reset)
//  start        in   1      issue a divide; sampled only in IDLE
//  signed_div   in   1      1 = DIV (two's complement), 0 = DIVU; sampled with start
//  annul        in   1      flush: abandon the current operation
//  opa          in   WIDTH  dividend (rs); sampled with start
//  opb          in   WIDTH  divisor (rt); sampled with start
//  stall        out  1      hold upstream pipeline stages
//  done         out  1      one-cycle pulse: hi_out/lo_out valid
//  div_by_zero  out  1      qualifies done: divisor was zero
//  hi_out       out  WIDTH  remainder
//  lo_out       out  WIDTH  quotient
// BEHAVIOUR
//  - Reset (rst==0 at a clock edge): state=IDLE, count=0, done=0, div_by_zero=0, hi_out=0, lo_out=0.
//    Reset overrides every other input, including mid-operation; no done follows.
//  - FSM states: IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: on start, latch |opa|, |opb|, sign_q=signed&(a[W-1]^b[W-1]), sign_r=signed&a[W-1],
//      and the raw opa. If opb==0, go to DONE directly; otherwise go to BUSY with count=0.
//    BUSY: one restoring step per cycle: {rem,quo}<<=1; if rem>=divisor, rem-=divisor and quo[0]=1.
//      count increments each step. After the step with count==WIDTH-1, go to DONE.
//    DONE: done=1 for exactly this cycle. Next state is IDLE unconditionally.
//  - Latency: start is seen at edge 0. done is high in cycle WIDTH+1, which is 33 cycles for WIDTH=32.
//    A divide by zero has done high in cycle 1.
//  - stall = (IDLE & start & ~annul) | BUSY. stall is 0 in DONE, so the stage advances in the same
//    cycle it captures the result.
//  - Results: hi_out/lo_out update only on entry to DONE and hold until the next DONE or reset.
//    Sign fix-up: lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem.
//    Unsigned remainder/subtract uses a WIDTH+1-bit compare.
//  - Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This is the natural
//    magnitude-wrap result; no trap.
//  - Divide by zero: lo={WIDTH{1}}, hi=raw opa, div_by_zero=1 during the done cycle; 0 otherwise.
//  - annul in BUSY or DONE: next state is IDLE. No done pulse; hi_out/lo_out are unchanged.
//    annul together with start in IDLE: the start is ignored.
//  - start while BUSY/DONE: ignored. The operand latches are not disturbed.
//  - start in the same cycle as done is not accepted; the FSM must pass through IDLE first.
// STRUCTURE
//  - In defines.vh: `DIV_IDLE/`DIV_BUSY/`DIV_DONE 2-bit state encodings and `DIV_WIDTH.
//  - One sub-module, div_step: combinational single restoring step.
//    Inputs: rem, quo, divisor. Outputs: next rem, next quo.
//    Instantiated once; div_unit holds the FSM, counter, latches and sign fix-up.
// TESTING
//  1. DIVU 7/2: start with opa=7, opb=2, signed_div=0.
//     Expect stall high for cycles 0..32, done in cycle 33, lo=3, hi=1.
//  2. DIV -7/2: opa=0xFFFFFFF9, opb=2, signed_div=1.
//     Expect lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     Then DIVU on the same operands: expect lo=0x7FFFFFFC, hi=1.
//  3. Overflow: DIV with opa=0x80000000, opb=0xFFFFFFFF.
//     Expect lo=0x80000000, hi=0, div_by_zero=0.
//  4. Divide by zero: DIV with opa=0x12345678, opb=0.
//     Expect done in cycle 1, div_by_zero=1, lo=0xFFFFFFFF, hi=0x12345678.
//  5. annul at cycle 10 of a DIVU 100/7.
//     Expect IDLE in cycle 11, no done, hi/lo still holding the previous result.
//     Then a fresh start computes lo=14, hi=2.
//  6. Drive rst=0 at cycle 5 of an active divide: expect all outputs 0 and no done.
//     Hold start high across a busy period: expect exactly one operation and one done.

Source files
------------

// File: rtl/div_unit_pkg.sv
// div_unit_pkg
//   Shared definitions for the execute-stage divider: default operand width
//   and the 2-bit FSM state encoding used by div_unit.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage : div_unit_pkg

// File: rtl/div_step.sv
// div_step
//   One combinational radix-2 restoring division step.
//   Ports:
//     rem      in   WIDTH  partial remainder before the step
//     quo      in   WIDTH  dividend/quotient shift register before the step
//     divisor  in   WIDTH  divisor magnitude
//     rem_next out  WIDTH  partial remainder after the step
//     quo_next out  WIDTH  quotient shift register after the step
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // The shifted remainder can reach 2*divisor-1, so the compare needs one
    // extra bit. The subtraction itself fits in WIDTH bits because the
    // result is always below the divisor.
    logic [WIDTH:0] partial;
    logic           fits;

    always_comb begin
        partial  = {rem, quo[WIDTH-1]};
        fits     = (partial >= {1'b0, divisor});
        rem_next = partial[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (fits) begin
            rem_next = partial[WIDTH-1:0] - divisor;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule : div_step

// File: rtl/div_unit.sv
// div_unit
//   Multi-cycle restoring divider for DIV/DIVU. Operands are converted to
//   magnitudes on issue, iterated one bit per cycle, and sign-corrected when
//   the last step completes. Results hold until the next completed divide.
//   Ports:
//     clk          in   1      rising-edge clock
//     rst          in   1      synchronous reset, active low
//     start        in   1      issue a divide (accepted only in IDLE)
//     signed_div   in   1      1 = DIV, 0 = DIVU
//     annul        in   1      abandon the current operation
//     opa          in   WIDTH  dividend
//     opb          in   WIDTH  divisor
//     stall        out  1      hold upstream pipeline stages
//     done         out  1      one-cycle result-valid pulse
//     div_by_zero  out  1      qualifies done: divisor was zero
//     hi_out       out  WIDTH  remainder
//     lo_out       out  WIDTH  quotient
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    div_state_t       state;
    div_state_t       next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic             sign_q;
    logic             sign_r;
    logic             dz_q;
    logic             load;
    logic             step_en;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;

    assign a_mag  = (signed_div && opa[WIDTH-1]) ? -opa : opa;
    assign b_mag  = (signed_div && opb[WIDTH-1]) ? -opb : opb;
    assign b_zero = (opb == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // done/div_by_zero are suppressed when annul arrives in the DONE cycle.
    always_comb begin
        next_state  = state;
        stall       = 1'b0;
        done        = 1'b0;
        div_by_zero = 1'b0;
        load        = 1'b0;
        step_en     = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (start && !annul) begin
                    stall      = 1'b1;
                    load       = 1'b1;
                    next_state = b_zero ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                stall = 1'b1;
                if (annul) begin
                    next_state = DIV_IDLE;
                end else begin
                    step_en = 1'b1;
                    if (count == LAST) begin
                        next_state = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                done        = !annul;
                div_by_zero = dz_q && !annul;
                next_state  = DIV_IDLE;
            end
            default: begin
                next_state = DIV_IDLE;
            end
        endcase
    end

    // Operand latches, iteration registers and the published result.
    // Results are written only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dz_q      <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
        end else if (load) begin
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= a_mag;
            divisor_q <= b_mag;
            sign_q    <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            sign_r    <= signed_div & opa[WIDTH-1];
            dz_q      <= b_zero;
            if (b_zero) begin
                lo_out <= '1;
                hi_out <= opa;
            end
        end else if (step_en) begin
            count <= count + 1'b1;
            rem_q <= rem_next;
            quo_q <= quo_next;
            if (count == LAST) begin
                lo_out <= sign_q ? -quo_next : quo_next;
                hi_out <= sign_r ? -rem_next : rem_next;
            end
        end
    end

endmodule : div_unit
